// File: rtl/reduce_pkg.sv
// Shared mode encodings and gate helpers for the configurable reduction tree.
package reduce_pkg;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  // Value that leaves the other operand unchanged; NOR reduces as OR.
  function automatic logic identity(input logic [1:0] mode);
    return (mode == MODE_AND);
  endfunction

  // One 2-input tree gate; NOR inversion happens once at the tree root.
  function automatic logic combine(input logic a, input logic b, input logic [1:0] mode);
    case (mode)
      MODE_AND: return a & b;
      MODE_XOR: return a ^ b;
      default:  return a | b;
    endcase
  endfunction

  // Number of live operands after k levels of pairing an n-input vector.
  function automatic int level_width(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: pairs adjacent operands, pads an odd tail with the identity
// element, and optionally registers the result together with its mode.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = (W_IN + 1) / 2,
  parameter bit REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_IN-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  output logic [W_OUT-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic [W_OUT-1:0] pair;

  for (genvar i = 0; i < W_OUT; i++) begin : g_pair
    if (2 * i + 1 < W_IN) begin : g_full
      assign pair[i] = combine(in_data[2*i], in_data[2*i+1], in_mode);
    end else begin : g_pad
      assign pair[i] = combine(in_data[2*i], identity(in_mode), in_mode);
    end
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) out_valid <= 1'b0;
      else     out_valid <= in_valid;
    end

    // NOTE: data and mode registers carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
      out_data <= pair;
      out_mode <= in_mode;
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = pair;
    assign out_mode       = in_mode;
  end

endmodule

// File: rtl/bigger_reduce_gate.sv
// Pipelined N_IN-bit OR/AND/XOR/NOR reduction with a registered result and a
// sticky-OR accumulator over qualifying results.
module bigger_reduce_gate
  import reduce_pkg::*;
#(
  parameter int N_IN = 8,
  parameter bit PIPE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  input  logic [1:0]      mode,
  input  logic            acc_en,
  input  logic            acc_clr,
  output logic            out_valid,
  output logic            out,
  output logic            acc_out
);

  localparam int LEVELS = $clog2(N_IN);

  // The root level stays combinational and feeds the output register, so a
  // fully pipelined tree has exactly LEVELS register stages.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int W_IN  = level_width(N_IN, k);
    localparam int W_OUT = level_width(N_IN, k + 1);

    logic             v_in;
    logic [W_IN-1:0]  d_in;
    logic [1:0]       m_in;
    logic             v_out;
    logic [W_OUT-1:0] d_out;
    logic [1:0]       m_out;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign d_in = in_data;
      assign m_in = mode;
    end else begin : g_link
      assign v_in = g_lvl[k-1].v_out;
      assign d_in = g_lvl[k-1].d_out;
      assign m_in = g_lvl[k-1].m_out;
    end

    reduce_stage #(
      .W_IN (W_IN),
      .W_OUT(W_OUT),
      .REG  (PIPE && (k < LEVELS - 1))
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_in),
      .in_data  (d_in),
      .in_mode  (m_in),
      .out_valid(v_out),
      .out_data (d_out),
      .out_mode (m_out)
    );
  end

  logic       root_valid;
  logic       root_data;
  logic [1:0] root_mode;
  logic       qualify;

  assign root_valid = g_lvl[LEVELS-1].v_out;
  assign root_data  = g_lvl[LEVELS-1].d_out[0];
  assign root_mode  = g_lvl[LEVELS-1].m_out;
  assign qualify    = out_valid & acc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else begin
      out_valid <= root_valid;
      if (root_valid) out <= (root_mode == MODE_NOR) ? ~root_data : root_data;
    end
  end

  // Clear wins over accumulation, then a simultaneous qualifying result is loaded.
  always_ff @(posedge clk) begin
    if (rst)          acc_out <= 1'b0;
    else if (acc_clr) acc_out <= qualify & out;
    else if (qualify) acc_out <= acc_out | out;
  end

endmodule

// File: doc/bigger_reduce_gate.md
BIGGER_REDUCE_GATE -- requirements
Module: bigger_reduce_gate

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning the number of single-bit inputs reduced (legal range 2..64).
REQ-002 SHALL have parameter PIPE, default 1, meaning 1 registers every tree level and 0 registers the output only.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and mode are valid this cycle.
REQ-006 SHALL have port in_data, input, N_IN bits: the operand bits in0..in(N_IN-1).
REQ-007 SHALL have port mode, input, 2 bits: 00 OR, 01 AND, 10 XOR, 11 NOR; sampled with in_data.
REQ-008 SHALL have port acc_en, input, 1 bit: enables the sticky accumulator on each qualifying result.
REQ-009 SHALL have port acc_clr, input, 1 bit: restarts the accumulator.
REQ-010 SHALL have port out_valid, output, 1 bit: out carries a result this cycle.
REQ-011 SHALL have port out, output, 1 bit: the reduction result.
REQ-012 SHALL have port acc_out, output, 1 bit: the sticky-OR of accumulated results.

Function
REQ-013 SHALL compute a binary reduction tree of LEVELS = clog2(N_IN) levels of 2-input gates.
REQ-014 SHALL pad non-power-of-two N_IN with the identity element: 0 for OR, XOR and NOR; 1 for AND.
REQ-015 SHALL implement NOR as an OR tree with the final result inverted.
REQ-016 SHALL carry mode alongside data through every stage, so each sample uses its own mode and mode may change every cycle.
REQ-017 SHALL, when PIPE=1, give a latency of LEVELS cycles from in_valid to out_valid, with throughput 1 sample per cycle.
REQ-018 SHALL, when PIPE=0, give a latency of 1 cycle (combinational tree, registered output).
REQ-019 SHALL advance a valid bit per stage, with no backpressure and no stall.
REQ-020 SHALL drive out only when out_valid=1 and hold its last value when out_valid=0.
REQ-021 SHALL, on a qualifying result (out_valid=1, acc_en=1), update acc_out <= acc_out | out in the following cycle.
REQ-022 SHALL, on acc_clr=1 with no qualifying result, set acc_out to 0 in the next cycle.
REQ-023 SHALL, when acc_clr=1 and a qualifying result occur together, set acc_out to out (clear wins, then load).
REQ-024 SHALL leave acc_out unchanged when acc_en=0, regardless of out_valid.

Reset
REQ-025 SHALL, while rst=1, set out_valid=0, out=0, acc_out=0 and every stage valid bit to 0.
REQ-026 SHALL discard samples in flight at reset, so no out_valid is generated for them after rst deasserts.
REQ-027 SHALL accept a sample whose in_valid is high in the first cycle after rst deasserts.
REQ-028 SHALL allow stage data registers to be left unreset, since valid gating covers them.

Structure
REQ-029 SHALL place the mode encodings (OR/AND/XOR/NOR) and the identity-element function in a shared package, reduce_pkg.
REQ-030 SHALL contain one sub-module, reduce_stage: one tree level (combinational pairing plus an optional register, selected by PIPE) that is instantiated LEVELS times by generate.

Verification (N_IN=8, PIPE=1, LEVELS=3 unless stated)
REQ-031 SHALL cover: OR with 8'h00 then 8'h10 on consecutive cycles -> out 0 then 1, appearing at cycles +3 and +4.
REQ-032 SHALL cover: modes AND 8'hFF, AND 8'hFE, XOR 8'h07, NOR 8'h00 on back-to-back cycles -> out 1, 0, 1, 1 on consecutive valid cycles.
REQ-033 SHALL cover: N_IN=5, AND 5'h1F -> 1, and XOR 5'h10 -> 1 (padding correct).
REQ-034 SHALL cover: acc_en=1 with results 0, 1, 0 -> acc_out 0, 1, 1; then acc_clr together with result 0 -> acc_out 0.
REQ-035 SHALL cover: in_valid at cycle 0 and rst=1 at cycle 1 -> out_valid stays 0 through cycle 6, and acc_out=0.
REQ-036 SHALL cover: PIPE=0, OR 8'h01 -> out_valid=1 and out=1 exactly 1 cycle later.
